// File: rtl/conv_accum_ctrl_pkg.sv
// rtl/conv_accum_ctrl_pkg.sv - shared conv types, default widths and saturating add
package conv_accum_ctrl_pkg;

  localparam int DEF_WIDTH     = 9;
  localparam int DEF_ACC_WIDTH = 24;
  localparam int DEF_CH_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } conv_state_t;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } sat_res_t;

  // Operands arrive sign-extended to 64 bits; the result is clamped to a w-bit signed range.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int unsigned w);
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sat_res_t           r;
    sum   = a + b;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    r.ovf = 1'b0;
    r.val = sum;
    if (sum > max_v) begin
      r.ovf = 1'b1;
      r.val = max_v;
    end else if (sum < min_v) begin
      r.ovf = 1'b1;
      r.val = min_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_accum_ctrl_if.sv
// rtl/conv_accum_ctrl_if.sv - tree-sum input and result output handshakes of the accumulator
interface conv_accum_ctrl_if
  import conv_accum_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [2*WIDTH-1:0]   in_sum;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv_accum_ctrl_sat_accum.sv
// rtl/conv_accum_ctrl_sat_accum.sv - sat_accum: accumulator register, saturating add, sticky ovf
module sat_accum
  import conv_accum_ctrl_pkg::*;
#(
  parameter int SUM_W     = 2 * DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_i,
  input  logic signed [ACC_WIDTH-1:0] bias_i,
  input  logic                        add_i,
  input  logic signed [SUM_W-1:0]     sum_i,
  output logic signed [ACC_WIDTH-1:0] acc_o,
  output logic                        ovf_o
);
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        ovf_q, ovf_d;
  sat_res_t                    res;
  logic                        unused_hi;

  // Range compare on the widened sum is equivalent to checking the ACC_WIDTH+1 carry bit.
  assign res       = sat_add(64'(acc_q), 64'(sum_i), ACC_WIDTH);
  assign unused_hi = ^res.val[63:ACC_WIDTH];

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (load_i) begin
      acc_d = bias_i;
      ovf_d = 1'b0;
    end else if (add_i) begin
      acc_d = res.val[ACC_WIDTH-1:0];
      ovf_d = ovf_q | res.ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/conv_accum_ctrl.sv
// rtl/conv_accum_ctrl.sv - per-pixel bias + channel accumulation sequencer after the conv adder tree
// Optional ReLU on the result under CONV_ACCUM_RELU_EN.
module conv_accum_ctrl
  import conv_accum_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CH_W      = DEF_CH_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [CH_W-1:0]             cfg_num_ch_i,
  input  logic signed [ACC_WIDTH-1:0] cfg_bias_i,
  output logic                        busy_o,
  output logic                        ovf_o,
  output logic                        done_o,
  conv_accum_ctrl_if.slave            io
);
  if (ACC_WIDTH < 2 * WIDTH || ACC_WIDTH > 62) begin : g_bad_width
    $error("conv_accum_ctrl: ACC_WIDTH must be in [2*WIDTH, 62]");
  end

  conv_state_t                 state_q, state_d;
  logic [CH_W-1:0]             cnt_q, cnt_d;
  logic [CH_W-1:0]             num_ch_q, num_ch_d;
  logic                        done_q, done_d;
  logic                        load, add;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] res_data;

  sat_accum #(
    .SUM_W    (2 * WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_sat_accum (
    .clk   (clk),
    .rst   (rst),
    .load_i(load),
    .bias_i(cfg_bias_i),
    .add_i (add),
    .sum_i (io.in_sum),
    .acc_o (acc),
    .ovf_o (ovf_o)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_ch_d = num_ch_q;
    done_d   = 1'b0;
    load     = 1'b0;
    add      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load     = 1'b1;
          num_ch_d = cfg_num_ch_i;
          cnt_d    = '0;
          state_d  = (cfg_num_ch_i == '0) ? ST_OUT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (io.in_valid) begin
          add   = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == num_ch_q - 1'b1) state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (io.out_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      num_ch_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      num_ch_q <= num_ch_d;
      done_q   <= done_d;
    end
  end

`ifdef CONV_ACCUM_RELU_EN
  assign res_data = acc[ACC_WIDTH-1] ? '0 : acc;
`else
  assign res_data = acc;
`endif

  // Handshake outputs decode state only, so no input-to-output combinational path exists.
  assign busy_o       = (state_q != ST_IDLE);
  assign io.in_ready  = (state_q == ST_ACCUM);
  assign io.out_valid = (state_q == ST_OUT);
  assign io.out_data  = (state_q == ST_OUT) ? res_data : '0;
  assign done_o       = done_q;
endmodule

// File: tb/tb_conv_accum_ctrl.sv
// tb/tb_conv_accum_ctrl.sv - directed self-checking bench for conv_accum_ctrl
module tb_conv_accum_ctrl;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [7:0]         cfg_num_ch = '0;
  logic signed [23:0] cfg_bias = '0;
  logic               busy, ovf, done;
  int                 vec_cnt = 0;
  int                 err_cnt = 0;

`ifdef CONV_ACCUM_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif

  conv_accum_ctrl_if #(.WIDTH(9), .ACC_WIDTH(24)) bus ();

  conv_accum_ctrl #(.WIDTH(9), .ACC_WIDTH(24), .CH_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .cfg_num_ch_i(cfg_num_ch),
    .cfg_bias_i  (cfg_bias),
    .busy_o      (busy),
    .ovf_o       (ovf),
    .done_o      (done),
    .io          (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic signed [23:0] exp_out(input int v);
    if (RELU_ON && v < 0) return 24'sd0;
    return 24'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int bias, input int n);
    cfg_bias   = 24'(bias);
    cfg_num_ch = 8'(n);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    cfg_bias   = 24'sh5A5A5A;
    cfg_num_ch = 8'hAA;
  endtask

  task automatic feed(input int s);
    bus.in_valid = 1'b1;
    bus.in_sum   = 18'(s);
    tick();
    bus.in_valid = 1'b0;
    bus.in_sum   = 18'h15555;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    vec_cnt++;
    if ({busy, bus.in_ready, bus.out_valid, ovf, done} !== 5'b0) begin
      err_cnt++;
      $display("FAIL reset_flags got %b want 00000", {busy, bus.in_ready, bus.out_valid, ovf, done});
    end
    vec_cnt++;
    if (bus.out_data !== 24'sd0) begin
      err_cnt++;
      $display("FAIL reset_data got %0d want 0", bus.out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    do_start(10, 3);
    vec_cnt++;
    if ({busy, bus.in_ready} !== 2'b11) begin
      err_cnt++;
      $display("FAIL basic_accum_state got %b want 11", {busy, bus.in_ready});
    end
    feed(5);
    feed(-2);
    vec_cnt++;
    if (bus.out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_early_valid got %b want 0", bus.out_valid);
    end
    feed(7);
    vec_cnt++;
    if ({bus.out_valid, bus.in_ready, ovf} !== 3'b100) begin
      err_cnt++;
      $display("FAIL basic_out_state got %b want 100", {bus.out_valid, bus.in_ready, ovf});
    end
    vec_cnt++;
    if (bus.out_data !== exp_out(20)) begin
      err_cnt++;
      $display("FAIL basic_data got %0d want %0d", bus.out_data, exp_out(20));
    end
    tick();
    vec_cnt++;
    if ({done, busy, bus.out_valid} !== 3'b100) begin
      err_cnt++;
      $display("FAIL basic_done got %b want 100", {done, busy, bus.out_valid});
    end
    bus.out_ready = 1'b0;
    tick();
    vec_cnt++;
    if (done !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_done_width got %b want 0", done);
    end
  endtask

  task automatic test_stall();
    do_start(100, 2);
    feed(30);
    tick();
    tick();
    vec_cnt++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      err_cnt++;
      $display("FAIL stall_state got %b want 10", {bus.in_ready, bus.out_valid});
    end
    feed(-50);
    for (int i = 0; i < 4; i++) begin
      tick();
      vec_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_out(80) || done !== 1'b0) begin
        err_cnt++;
        $display("FAIL stall_hold%0d got v=%b d=%0d done=%b want v=1 d=%0d done=0",
                 i, bus.out_valid, bus.out_data, done, exp_out(80));
      end
    end
    drain();
    vec_cnt++;
    if (done !== 1'b1) begin
      err_cnt++;
      $display("FAIL stall_done got %b want 1", done);
    end
    tick();
    vec_cnt++;
    if ({done, busy} !== 2'b00) begin
      err_cnt++;
      $display("FAIL stall_single_done got %b want 00", {done, busy});
    end
  endtask

  task automatic test_saturation();
    do_start(8388600, 1);
    feed(100);
    vec_cnt++;
    if (bus.out_data !== exp_out(8388607) || ovf !== 1'b1) begin
      err_cnt++;
      $display("FAIL sat_pos got d=%0d ovf=%b want d=%0d ovf=1", bus.out_data, ovf, exp_out(8388607));
    end
    drain();
    tick();
    vec_cnt++;
    if (ovf !== 1'b1) begin
      err_cnt++;
      $display("FAIL sat_sticky got %b want 1", ovf);
    end
    do_start(-8388600, 1);
    vec_cnt++;
    if (ovf !== 1'b0) begin
      err_cnt++;
      $display("FAIL sat_clear got %b want 0", ovf);
    end
    feed(-100);
    vec_cnt++;
    if (bus.out_data !== exp_out(-8388608) || ovf !== 1'b1) begin
      err_cnt++;
      $display("FAIL sat_neg got d=%0d ovf=%b want d=%0d ovf=1", bus.out_data, ovf, exp_out(-8388608));
    end
    drain();
    tick();
  endtask

  task automatic test_bias_only();
    bus.in_valid = 1'b1;
    bus.in_sum   = 18'sd1000;
    do_start(-5, 0);
    vec_cnt++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10 || bus.out_data !== exp_out(-5)) begin
      err_cnt++;
      $display("FAIL bias_only got v=%b r=%b d=%0d want v=1 r=0 d=%0d",
               bus.out_valid, bus.in_ready, bus.out_data, exp_out(-5));
    end
    tick();
    vec_cnt++;
    if (bus.out_data !== exp_out(-5) || bus.in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL bias_only_ignore got d=%0d r=%b want d=%0d r=0", bus.out_data, bus.in_ready, exp_out(-5));
    end
    bus.in_valid = 1'b0;
    drain();
    tick();
  endtask

  task automatic test_start_ignored();
    do_start(1, 3);
    feed(4);
    cfg_bias   = 24'sd1000;
    cfg_num_ch = 8'd1;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    vec_cnt++;
    if ({busy, bus.out_valid} !== 2'b10) begin
      err_cnt++;
      $display("FAIL ign_state got %b want 10", {busy, bus.out_valid});
    end
    feed(6);
    vec_cnt++;
    if (bus.out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL ign_count got %b want 0", bus.out_valid);
    end
    feed(10);
    vec_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_out(21)) begin
      err_cnt++;
      $display("FAIL ign_data got v=%b d=%0d want v=1 d=%0d", bus.out_valid, bus.out_data, exp_out(21));
    end
    drain();
    tick();
  endtask

  task automatic test_async_reset();
    do_start(7, 4);
    feed(1);
    feed(2);
    #3;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({busy, bus.in_ready, bus.out_valid, ovf, done} !== 5'b0 || bus.out_data !== 24'sd0) begin
      err_cnt++;
      $display("FAIL arst_outputs got %b d=%0d want 00000 d=0",
               {busy, bus.in_ready, bus.out_valid, ovf, done}, bus.out_data);
    end
    tick();
    rst = 1'b0;
    do_start(0, 1);
    feed(3);
    vec_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_out(3)) begin
      err_cnt++;
      $display("FAIL arst_restart got v=%b d=%0d want v=1 d=%0d", bus.out_valid, bus.out_data, exp_out(3));
    end
    drain();
    tick();
  endtask

  task automatic test_back_to_back();
    do_start(2, 1);
    feed(5);
    vec_cnt++;
    if (bus.out_data !== exp_out(7)) begin
      err_cnt++;
      $display("FAIL b2b_first got %0d want %0d", bus.out_data, exp_out(7));
    end
    drain();
    vec_cnt++;
    if (done !== 1'b1) begin
      err_cnt++;
      $display("FAIL b2b_done got %b want 1", done);
    end
    do_start(3, 0);
    vec_cnt++;
    if ({busy, bus.out_valid, done} !== 3'b110 || bus.out_data !== exp_out(3)) begin
      err_cnt++;
      $display("FAIL b2b_second got %b d=%0d want 110 d=%0d", {busy, bus.out_valid, done}, bus.out_data, exp_out(3));
    end
    drain();
    tick();
  endtask

  task automatic test_max_ch();
    do_start(0, 255);
    for (int i = 0; i < 254; i++) feed(1);
    vec_cnt++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      err_cnt++;
      $display("FAIL max_ch_early got %b want 10", {bus.in_ready, bus.out_valid});
    end
    feed(1);
    vec_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_out(255)) begin
      err_cnt++;
      $display("FAIL max_ch_data got v=%b d=%0d want v=1 d=%0d", bus.out_valid, bus.out_data, exp_out(255));
    end
    drain();
    tick();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_saturation();
    test_bias_only();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    test_max_ch();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/conv_accum_ctrl.md
Name: conv_accum_ctrl

Overview:
- Sequencer that sits on the output of the 3x3 convolution adder tree.
- Accepts one tree sum per input channel through a valid/ready handshake and accumulates NUM_CH partial sums on top of a per-filter bias.
- Presents one saturated result per output pixel through a valid/ready handshake toward the pooling/writeback stage.
- Owns start/busy/done sequencing for one output pixel.

Parameters:
WIDTH, 9, operand width of the conv multipliers; the tree sum is 2*WIDTH bits signed
ACC_WIDTH, 24, accumulator and result width, signed
CH_W, 8, width of the channel-count configuration

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse that begins one pixel; sampled only in IDLE
cfg_num_ch  input  CH_W  number of input channels to accumulate, latched on start
cfg_bias  input  ACC_WIDTH  signed bias, latched on start
busy  output  1  high in every state except IDLE
in_valid  input  1  tree sum valid
in_ready  output  1  controller accepts a tree sum
in_sum  input  2*WIDTH  signed adder-tree sum
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_data  output  ACC_WIDTH  signed result
ovf  output  1  sticky saturation flag for the current pixel
done  output  1  one-cycle pulse on the result handshake

Behaviour:
- Reset is asynchronous and active-high. While rst is high, all of the following are 0: state=IDLE, acc, cnt, busy, in_ready, out_valid, out_data, ovf, done. Asserting rst mid-pixel abandons the pixel with no output.
- States: IDLE, ACCUM, OUT. All outputs are registered or decoded from state only; there is no combinational path from in_valid or out_ready to any output.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with cfg_num_ch!=0: acc<=cfg_bias, num_ch<=cfg_num_ch, cnt<=0, ovf<=0, go to ACCUM.
  - start=1 with cfg_num_ch==0: acc<=cfg_bias, ovf<=0, go directly to OUT (bias-only pixel).
- ACCUM:
  - in_ready=1.
  - Each cycle with in_valid&in_ready: acc<=sat(acc+sext(in_sum)), cnt<=cnt+1.
  - Saturating add: on positive overflow clamp to 2^(ACC_WIDTH-1)-1; on negative overflow clamp to -2^(ACC_WIDTH-1). Either case sets ovf, which stays set until the next start.
  - The handshake with cnt==num_ch-1 is the last one; go to OUT on the next edge.
  - in_valid low produces a stall: no change.
- OUT:
  - in_ready=0, out_valid=1, out_data=acc.
  - out_data is held stable while out_ready=0.
  - On out_valid&out_ready: done=1 for exactly that following cycle, go to IDLE.
- Latency:
  - Last input handshake at edge N gives out_valid high after edge N.
  - Result handshake at edge M gives done high for cycle M to M+1 and busy low after M.
  - Back-to-back pixels: start may be asserted in the cycle done is high. The earliest restart is one cycle after the output handshake.
- start while busy is ignored and has no side effects. cfg_* are don't-care except in the start cycle.
- in_valid while not in ACCUM is ignored: no handshake, no accumulation.
- Width rule: in_sum is sign-extended from 2*WIDTH to ACC_WIDTH+1 before the add. Overflow is detected on the extra bit. ACC_WIDTH>=2*WIDTH is required (elaboration error otherwise).
- Counter: cnt is CH_W bits wide. cfg_num_ch=2^CH_W-1 is the maximum and produces no wrap.

Optional Feature:
- Macro CONV_ACCUM_RELU_EN.
- Defined: in OUT, out_data = (acc<0) ? 0 : acc. ReLU is applied after saturation; ovf is unaffected.
- Undefined: out_data = acc, raw signed.
- Timing and handshake are identical in both builds.

Decomposition:
- Shared conv package holds:
  - the state enumeration (IDLE/ACCUM/OUT)
  - default constants WIDTH=9, ACC_WIDTH=24, CH_W=8
  - a saturating-add function parameterised on widths, reused by the pooling stage.
- One natural sub-module: sat_accum, holding the accumulator register, the saturating add and ovf generation. The FSM and counter stay in conv_accum_ctrl.

Test Plan:
1. bias=10, num_ch=3, in_sum=5,-2,7 with continuous in_valid and out_ready=1 -> out_data=20, out_valid one cycle after the 3rd handshake, done pulse, ovf=0.
2. num_ch=2, in_valid toggling 1,0,0,1 with out_ready held 0 for 4 cycles -> stalls do not accumulate; out_data=bias+sum held stable for 4 cycles; single done on release.
3. bias=8388600 (ACC_WIDTH=24), num_ch=1, in_sum=100 -> out_data=8388607, ovf=1. A repeat with bias=-8388600 and in_sum=-100 -> -8388608, ovf=1.
4. num_ch=0, bias=-5 -> OUT reached one cycle after start, in_ready never high, out_data=-5 (0 with CONV_ACCUM_RELU_EN).
5. start pulsed during ACCUM with different cfg values -> ignored; the result uses the original bias/num_ch.
6. rst asserted asynchronously mid-ACCUM after 2 of 4 inputs -> all outputs 0 immediately. A following start with bias=0, num_ch=1, in_sum=3 -> out_data=3.
